// File: rtl/seq_alu_if.sv
// Operation/result bus for seq_alu.
// Handshake: a transfer happens only on a rising edge where valid && ready.
// The producer holds its payload stable while valid is high and not yet
// taken; the consumer may drive ready independently of valid.
interface seq_alu_if #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;
  logic               carry;
  logic               zero;
  logic               dbz;
  logic               illegal;
  logic [1:0]         state;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, z, carry, zero, dbz, illegal, state
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, z, carry, zero, dbz, illegal, state
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide. One operation in flight; result held until taken.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_mul;
  logic [WIDTH-1:0]   opnd;   // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0] prod;   // {partial sum, remaining multiplier bits}
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;    // dividend bits shift out as quotient shifts in

  logic [2*WIDTH-1:0] z_q;
  logic               carry_q, zero_q, dbz_q, illegal_q;

  // Single-cycle result from the operands presented on the bus
  logic [WIDTH:0]     ext_sum, ext_diff;
  logic [2*WIDTH-1:0] s_z;
  logic               s_carry, s_dbz, s_ill, s_long;

  assign ext_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign ext_diff = {1'b0, bus.a} - {1'b0, bus.b};

  // Decode the opcode into a direct result or a request for the iterative path
  always_comb begin
    s_z     = '0;
    s_carry = 1'b0;
    s_dbz   = 1'b0;
    s_ill   = 1'b0;
    s_long  = 1'b0;
    case (bus.op)
      4'b0000: begin s_z = {{(WIDTH-1){1'b0}}, ext_sum};  s_carry = ext_sum[WIDTH]; end
      4'b0001: begin s_z = {{(WIDTH-1){1'b0}}, ext_diff}; s_carry = (bus.a < bus.b); end
      4'b0010: begin
        if (bus.b == '0) s_dbz  = 1'b1;
        else             s_long = 1'b1;
      end
      4'b0011: s_long = 1'b1;
      4'b0100: s_z = {{WIDTH{1'b0}}, bus.a & bus.b};
      4'b0101: s_z = {{WIDTH{1'b0}}, bus.a | bus.b};
      4'b0110: s_z = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      4'b0111: s_z = {{WIDTH{1'b0}}, ~bus.a};
      4'b1000: begin s_z = {{(WIDTH-1){1'b0}}, bus.a, 1'b0}; s_carry = bus.a[WIDTH-1]; end
      4'b1001: begin s_z = {{(WIDTH+1){1'b0}}, bus.a[WIDTH-1:1]}; s_carry = bus.a[0]; end
      default: s_ill = 1'b1;
    endcase
  end

  // One step of each iterative algorithm
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic               div_ge;

  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
  assign prod_next = {mul_sum, prod[WIDTH-1:1]};
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], div_ge};

  // Control FSM, working registers and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_mul    <= 1'b0;
      opnd      <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      z_q       <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (s_long) begin
              state  <= BUSY;
              cnt    <= '0;
              is_mul <= (bus.op == 4'b0011);
              opnd   <= (bus.op == 4'b0011) ? bus.a : bus.b;
              prod   <= {{WIDTH{1'b0}}, bus.b};
              rem    <= '0;
              quo    <= bus.a;
            end else begin
              state     <= DONE;
              z_q       <= s_z;
              carry_q   <= s_carry;
              zero_q    <= (s_z == '0);
              dbz_q     <= s_dbz;
              illegal_q <= s_ill;
            end
          end
        end
        BUSY: begin
          cnt  <= cnt + 1'b1;
          prod <= prod_next;
          rem  <= rem_next;
          quo  <= quo_next;
          if (cnt == LAST) begin
            state     <= DONE;
            dbz_q     <= 1'b0;
            illegal_q <= 1'b0;
            if (is_mul) begin
              z_q     <= prod_next;
              carry_q <= |prod_next[2*WIDTH-1:WIDTH];
              zero_q  <= (prod_next == '0);
            end else begin
              z_q     <= {rem_next, quo_next};
              carry_q <= 1'b0;
              zero_q  <= ({rem_next, quo_next} == '0);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.z         = z_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.dbz       = dbz_q;
  assign bus.illegal   = illegal_q;
  assign bus.state     = state;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): directed cases plus randomized operations
// against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  seq_alu_if #(.WIDTH(W)) bus_if ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: results straight from the arithmetic definitions
  task automatic ref_model(input int unsigned o, input int unsigned x, input int unsigned y,
                           output logic [2*W-1:0] ez, output logic ec, output logic edz,
                           output logic eil, output int elat);
    int unsigned r;
    r = 0; ec = 0; edz = 0; eil = 0; elat = 1;
    case (o)
      0: begin r = x + y; ec = (r >= (1 << W)); end
      1: begin r = (x - y) & ((1 << (W + 1)) - 1); ec = (x < y); end
      2: begin
        if (y == 0) edz = 1;
        else begin r = ((x % y) << W) | (x / y); elat = W + 1; end
      end
      3: begin r = x * y; ec = (r >= (1 << W)); elat = W + 1; end
      4: r = x & y;
      5: r = x | y;
      6: r = x ^ y;
      7: r = (~x) & ((1 << W) - 1);
      8: begin r = (x << 1) & ((1 << (W + 1)) - 1); ec = x[W-1]; end
      9: begin r = x >> 1; ec = x[0]; end
      default: eil = 1;
    endcase
    ez = r[2*W-1:0];
  endtask

  task automatic garbage_inputs();
    bus_if.in_valid = 1'($urandom_range(0, 1));
    bus_if.a  = W'($urandom);
    bus_if.b  = W'($urandom);
    bus_if.op = 4'($urandom);
  endtask

  // Issue one op, track latency, check result, hold for 'hold' cycles, release
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hold);
    logic [2*W-1:0] ez, exp_z;
    logic ec, edz, eil;
    int   elat, lat;
    ref_model(o, x, y, ez, ec, edz, eil, elat);
    exp_q.push_back(ez);
    check("in_ready_idle", bus_if.in_ready, 1);
    bus_if.op = o; bus_if.a = x; bus_if.b = y; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 100) begin
      check("in_ready_busy", bus_if.in_ready, 0);
      garbage_inputs();
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check("out_valid", bus_if.out_valid, 1);
    exp_z = exp_q.pop_front();
    check("z", bus_if.z, exp_z);
    check("carry", bus_if.carry, ec);
    check("zero", bus_if.zero, (exp_z == 0));
    check("dbz", bus_if.dbz, edz);
    check("illegal", bus_if.illegal, eil);
    for (int i = 0; i < hold; i++) begin
      garbage_inputs();
      bus_if.in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", bus_if.out_valid, 1);
      check("hold_z", bus_if.z, exp_z);
      check("hold_carry", bus_if.carry, ec);
      check("hold_in_ready", bus_if.in_ready, 0);
    end
    garbage_inputs();
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    check("release_valid", bus_if.out_valid, 0);
    check("release_in_ready", bus_if.in_ready, 1);
  endtask

  initial begin
    int saw_valid;
    logic [3:0] ro;
    bus_if.in_valid = 1'b0; bus_if.a = '0; bus_if.b = '0; bus_if.op = '0;
    bus_if.out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_z", bus_if.z, 0);
    check("rst_flags", {bus_if.carry, bus_if.zero, bus_if.dbz, bus_if.illegal}, 0);
    rst = 1'b0;

    // directed cases
    do_op(4'b0000, 8'd200, 8'd100, 0);
    do_op(4'b0010, 8'd200, 8'd7, 0);
    do_op(4'b0010, 8'd55, 8'd0, 0);
    do_op(4'b0011, 8'd255, 8'd255, 0);
    do_op(4'b1111, 8'd12, 8'd34, 0);
    do_op(4'b0001, 8'd3, 8'd5, 5);

    // asynchronous reset in the middle of a multiply
    bus_if.op = 4'b0011; bus_if.a = 8'd10; bus_if.b = 8'd20; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", bus_if.in_ready, 1);
    check("arst_out_valid", bus_if.out_valid, 0);
    check("arst_z", bus_if.z, 0);
    check("arst_flags", {bus_if.carry, bus_if.zero, bus_if.dbz, bus_if.illegal}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid) saw_valid++;
    end
    check("aborted_no_valid", saw_valid, 0);
    do_op(4'b0000, 8'd1, 8'd1, 0);

    // edge operands
    do_op(4'b0010, 8'd255, 8'd1, 0);
    do_op(4'b0010, 8'd3, 8'd200, 0);
    do_op(4'b0011, 8'd0, 8'd77, 1);
    do_op(4'b0001, 8'd9, 8'd9, 0);
    do_op(4'b1000, 8'd128, 8'd0, 0);
    do_op(4'b1001, 8'd1, 8'd0, 0);

    // randomized operations
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) ro = 4'($urandom_range(0, 15));
      else ro = 4'($urandom_range(0, 9));
      do_op(ro, W'($urandom), ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
            $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand width; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 a, b  input  WIDTH each  unsigned operands.
REQ-007 op  input  4  opcode: 0000 add, 0001 sub, 0010 div, 0011 mul, 0100 and, 0101 or, 0110 xor, 0111 not-a, 1000 shl, 1001 shr, others illegal.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 z  output  2*WIDTH  registered result.
REQ-011 carry, zero, dbz, illegal  output  1 each  registered status flags.

Function
REQ-012 States IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 Accept = in_valid && in_ready at a rising edge; a, b, op captured on accept; inputs ignored at all other times.
REQ-014 Single-cycle ops (all except mul, div with b!=0): IDLE -> DONE on accept; out_valid high the next cycle (latency 1).
REQ-015 mul, and div with b!=0: IDLE -> BUSY on accept; exactly WIDTH iteration cycles; BUSY -> DONE; out_valid high WIDTH+1 cycles after accept.
REQ-016 DONE: out_valid=1, z and flags held stable; DONE -> IDLE at edge where out_ready=1; out_valid low in IDLE/BUSY.
REQ-017 add: z[WIDTH:0] = a+b; upper bits 0; carry = z[WIDTH].
REQ-018 sub: z[WIDTH:0] = (a-b) mod 2^(WIDTH+1); upper bits 0; carry = borrow = (a<b).
REQ-019 div: iterative restoring; z[WIDTH-1:0] = quotient, z[2*WIDTH-1:WIDTH] = remainder; carry=0.
REQ-020 div with b==0: single-cycle path, z=0, dbz=1; dbz=0 for every other result.
REQ-021 mul: iterative shift-add; z = full 2*WIDTH-bit product; carry = 1 iff product >= 2^WIDTH.
REQ-022 and/or/xor/not-a: z[WIDTH-1:0] = bitwise result, upper bits 0, carry=0.
REQ-023 shl: z[WIDTH:0] = a<<1, carry = a[WIDTH-1]; shr: z = a>>1, carry = a[0].
REQ-024 Illegal op: z=0, illegal=1, latency 1; illegal=0 for legal ops.
REQ-025 zero = (z == 0), computed on final result, valid with out_valid.
REQ-026 Flags and z update only on transition into DONE; unchanged in IDLE and BUSY.
REQ-027 No overlap: a new op is never accepted while BUSY or DONE, even if out_ready and in_valid coincide; next accept earliest the cycle after DONE exits.

Reset
REQ-028 rst=1 forces, immediately and regardless of clk, state=IDLE, in_ready=1, out_valid=0, z=0, carry=zero=dbz=illegal=0, iteration counter and working registers 0.
REQ-029 Reset during BUSY or DONE aborts the operation; no out_valid for it after rst deasserts.
REQ-030 First accept possible at first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-031 add a=200 b=100, out_ready=1 -> out_valid 1 cycle after accept, z=0x012C, carry=1, zero=0.
REQ-032 div a=200 b=7 -> out_valid 9 cycles after accept, z=0x041C (rem 4, quo 28), dbz=0; in_ready=0 throughout.
REQ-033 div a=55 b=0 -> out_valid after 1 cycle, z=0, dbz=1, zero=1.
REQ-034 mul a=255 b=255 -> out_valid 9 cycles after accept, z=0xFE01, carry=1; then op=1111 -> z=0, illegal=1.
REQ-035 sub a=3 b=5 with out_ready=0 for 5 cycles -> z=0x01FE, carry=1 held stable, in_valid ignored, in_ready=0 until out_ready edge.
REQ-036 rst pulse mid-BUSY (mul, cycle 4) -> outputs cleared asynchronously, no out_valid for aborted op, next add 1+1 -> z=2.
